rv2t_mtimer_bus_bridge: RTL and testbench
=========================================

// Module: rv2t_mtimer_bus_bridge
// PURPOSE
//  Bus-side initiator for the machine-timer register port. Decodes CPU word accesses to the
//  memory-mapped MTIME/MTIMEH/MTIMECMP/MTIMECMPH window and drives the timer's
//  load_mtimecmp_low/high, mtimecmp_write_data and reg_read_addr pins. Captures reg_read_data
//  and guarantees a coherent 64-bit mtime read. Qualifies timer_triggered into the MTIP interrupt.
// PARAMETERS
//  XLEN         32            data width
//  ADDR_BITS    32            bus address width
//  MTIMER_BASE  32'h2000_0000 window base, 16-byte aligned
//  SMALL_TIMER  0             1: 32-bit timer; high words read 0, mtimecmph writes acked but not forwarded
// PORTS
//  clk                 in   1          sole clock
//  sync_reset          in   1          synchronous, active-high reset
//  mem_req             in   1          access request, held with stable fields until mem_ack
//  mem_we              in   1          1 = write, 0 = read
//  mem_addr            in   ADDR_BITS  byte address
//  mem_be              in   4          byte enables
//  mem_wdata           in   XLEN       write data
//  mem_ack             out  1          one-cycle completion pulse
//  mem_err             out  1          valid with mem_ack; unmapped offset or partial write
//  mem_rdata           out  XLEN       read data, valid with mem_ack
//  mtie                in   1          mie.MTIE enable
//  irq_mtip            out  1          qualified timer interrupt
//  load_mtimecmp_low   out  1          one-cycle pulse to timer
//  load_mtimecmp_high  out  1          one-cycle pulse to timer
//  mtimecmp_write_data out  XLEN       timer write data
//  reg_read_addr       out  2          00 mtime (latches high), 01 latched mtimeh, 10 cmp lo, 11 cmp hi
//  reg_read_data       in   XLEN       timer read data, registered: valid 1 cycle after reg_read_addr
//  timer_triggered     in   1          timer compare flag
// BEHAVIOUR
//  - Reset values: all outputs 0, except reg_read_addr=2'b10. FSM=IDLE, hi_valid=0.
//  - Decode in IDLE only. Hit when mem_addr[ADDR_BITS-1:4]==MTIMER_BASE[ADDR_BITS-1:4].
//    Offsets: 0x0 mtime, 0x4 mtimeh, 0x8 mtimecmp, 0xC mtimecmph.
//  - mem_addr[1:0]!=0, or a write with mem_be!=4'hF: mem_err=1, no timer side effect, ack at N+1.
//  - Writes to mtime/mtimeh: mem_err=1, ack at N+1 (read-only here).
//  - Any access completes with one mem_ack; the FSM returns to IDLE the same cycle.
//    The next request is accepted no earlier than the cycle after mem_ack.
//  - reg_read_addr is parked at 2'b10 whenever the FSM is not issuing 00, so the timer's
//    mtime_high latch only updates on a deliberate mtime read.
//  - Write cmp (accepted cycle N): load pulse plus mtimecmp_write_data registered, valid cycle N+1.
//    mem_ack at N+1. Exactly one load pulse per write.
//  - Read (accepted N): FSM IDLE->ISSUE->WAIT->RESP. reg_read_addr valid N+1.
//    reg_read_data sampled at end of N+2; mem_rdata/mem_ack registered, valid N+3.
//  - mtime read sets hi_valid=1. Every mtimeh read clears hi_valid.
//  - mtimeh read with hi_valid=0: first issue 00 (PRE_ISSUE->PRE_WAIT, data discarded),
//    then 01. Ack at N+5. With hi_valid=1: 01 only, ack at N+3.
//  - Any write clears hi_valid.
//  - SMALL_TIMER=1: mtimeh/mtimecmph reads return 0 with ack at N+1, no timer access.
//    mtimecmph write acks at N+1, no pulse.
//  - irq_mtip registered: timer_triggered & mtie & ~(load_mtimecmp_low|load_mtimecmp_high).
//    This masks the one stale cycle while the timer clears its flag after a load.
//  - mem_req dropping mid-transaction is illegal. sync_reset mid-transaction aborts with no ack.
//    A load pulse already high is deasserted in the reset cycle's next edge.
// STRUCTURE
//  - Shared package/header (RV2T_common.vh): window offsets, reg_read_addr codes,
//    FSM state encodings (IDLE, ISSUE, WAIT, PRE_ISSUE, PRE_WAIT, RESP).
//  - Optional sub-module rv2t_mtimer_addr_decode (combinational hit/offset/err).
//    Everything else is flat in this module.
// TESTING
//  - Write 0x0000_1234 to base+0x8 -> load_mtimecmp_low=1 for exactly 1 cycle at N+1,
//    mtimecmp_write_data=0x1234, mem_ack N+1, mem_err=0.
//  - Timer model mtime=0x0000_0005_FFFF_FFF0; read base+0x0 then base+0x4 -> 0xFFFF_FFF0
//    then 0x0000_0005 even if mtime carries between reads; acks at N+3 each.
//  - Cold read base+0x4 after reset -> reg_read_addr sequence 00 then 01, ack at N+5,
//    data = high word at the 00 sample.
//  - Write base+0x8 with mem_be=4'h3, and read base+0x2 -> mem_err=1, ack N+1, no load pulse,
//    reg_read_addr stays 10.
//  - timer_triggered=1, mtie=1 -> irq_mtip=1 next cycle; then write cmp -> irq_mtip=0 on the
//    cycle after the pulse; mtie=0 -> irq_mtip=0.
//  - Assert sync_reset in WAIT of a read -> no mem_ack, all outputs at reset values next cycle;
//    next read completes normally.

Source files
------------

// File: rtl/rv2t_mtimer_bus_bridge_pkg.sv
// Shared definitions for the machine-timer bus bridge: register window offsets,
// timer read-port codes and bridge FSM states.
package rv2t_mtimer_bus_bridge_pkg;

    // Word offsets inside the 16-byte window (mem_addr[3:2])
    localparam int OFF_MTIME     = 0;
    localparam int OFF_MTIMEH    = 1;
    localparam int OFF_MTIMECMP  = 2;
    localparam int OFF_MTIMECMPH = 3;

    // reg_read_addr codes understood by the timer
    localparam logic [1:0] RRA_MTIME  = 2'b00;
    localparam logic [1:0] RRA_MTIMEH = 2'b01;
    localparam logic [1:0] RRA_CMP_LO = 2'b10;
    localparam logic [1:0] RRA_CMP_HI = 2'b11;
    // Idle code: reading compare-low has no side effect on the timer's high latch
    localparam logic [1:0] RRA_PARK   = RRA_CMP_LO;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_PRE_ISSUE = 3'd3,
        ST_PRE_WAIT  = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/rv2t_mtimer_addr_decode.sv
// Combinational decode of a bus access into the timer window: one-hot register
// select, error classification and small-timer high-word detection.
module rv2t_mtimer_addr_decode
    import rv2t_mtimer_bus_bridge_pkg::*;
#(
    parameter int                   ADDR_BITS   = 32,
    parameter logic [ADDR_BITS-1:0] MTIMER_BASE = 32'h2000_0000,
    parameter int                   SMALL_TIMER = 0
) (
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [3:0]           mem_be,
    output logic [3:0]           dec_sel,
    output logic                 dec_err,
    output logic                 dec_small_hi
);

    logic hit;
    logic misaligned;
    logic partial_write;
    logic ro_write;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign dec_sel[gi] = (mem_addr[3:2] == 2'(gi));
        end
    endgenerate

    assign hit           = (mem_addr[ADDR_BITS-1:4] == MTIMER_BASE[ADDR_BITS-1:4]);
    assign misaligned    = |mem_addr[1:0];
    assign partial_write = mem_we && (mem_be != 4'hF);
    // mtime/mtimeh are read-only through this port
    assign ro_write      = mem_we && (dec_sel[OFF_MTIME] || dec_sel[OFF_MTIMEH]);

    assign dec_err      = !hit || misaligned || partial_write || ro_write;
    assign dec_small_hi = (SMALL_TIMER != 0) && (dec_sel[OFF_MTIMEH] || dec_sel[OFF_MTIMECMPH]);

endmodule

// File: rtl/rv2t_mtimer_bus_bridge.sv
// Bus-side initiator for the machine-timer register port: decodes CPU word accesses,
// sequences timer reads for a coherent 64-bit mtime and qualifies the MTIP interrupt.
module rv2t_mtimer_bus_bridge
    import rv2t_mtimer_bus_bridge_pkg::*;
#(
    parameter int                   XLEN        = 32,
    parameter int                   ADDR_BITS   = 32,
    parameter logic [ADDR_BITS-1:0] MTIMER_BASE = 32'h2000_0000,
    parameter int                   SMALL_TIMER = 0
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [3:0]           mem_be,
    input  logic [XLEN-1:0]      mem_wdata,
    output logic                 mem_ack,
    output logic                 mem_err,
    output logic [XLEN-1:0]      mem_rdata,
    input  logic                 mtie,
    output logic                 irq_mtip,
    output logic                 load_mtimecmp_low,
    output logic                 load_mtimecmp_high,
    output logic [XLEN-1:0]      mtimecmp_write_data,
    output logic [1:0]           reg_read_addr,
    input  logic [XLEN-1:0]      reg_read_data,
    input  logic                 timer_triggered
);

    logic [3:0] dec_sel;
    logic       dec_err;
    logic       dec_small_hi;

    state_t          state_reg, state_next;
    logic            hi_valid_reg, hi_valid_next;
    logic            ack_reg, ack_next;
    logic            err_reg, err_next;
    logic [XLEN-1:0] rdata_reg, rdata_next;
    logic            load_lo_reg, load_lo_next;
    logic            load_hi_reg, load_hi_next;
    logic [XLEN-1:0] wdata_reg, wdata_next;
    logic [1:0]      rra_reg, rra_next;
    logic            irq_reg;

    rv2t_mtimer_addr_decode #(
        .ADDR_BITS   (ADDR_BITS),
        .MTIMER_BASE (MTIMER_BASE),
        .SMALL_TIMER (SMALL_TIMER)
    ) u_decode (
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .dec_sel      (dec_sel),
        .dec_err      (dec_err),
        .dec_small_hi (dec_small_hi)
    );

    always_comb begin
        state_next    = state_reg;
        hi_valid_next = hi_valid_reg;
        ack_next      = 1'b0;
        err_next      = 1'b0;
        rdata_next    = '0;
        load_lo_next  = 1'b0;
        load_hi_next  = 1'b0;
        wdata_next    = wdata_reg;
        rra_next      = RRA_PARK;

        case (state_reg)
            ST_IDLE: begin
                if (mem_req) begin
                    if (mem_we) begin
                        hi_valid_next = 1'b0;
                    end
                    if (dec_err) begin
                        ack_next   = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end else if (mem_we) begin
                        // Only compare registers are writable once errors are excluded
                        ack_next   = 1'b1;
                        state_next = ST_RESP;
                        if (dec_sel[OFF_MTIMECMP]) begin
                            load_lo_next = 1'b1;
                            wdata_next   = mem_wdata;
                        end else if (!dec_small_hi) begin
                            load_hi_next = 1'b1;
                            wdata_next   = mem_wdata;
                        end
                    end else if (dec_small_hi) begin
                        ack_next   = 1'b1;
                        state_next = ST_RESP;
                        if (dec_sel[OFF_MTIMEH]) begin
                            hi_valid_next = 1'b0;
                        end
                    end else if (dec_sel[OFF_MTIMEH]) begin
                        // Without a fresh mtime read the high latch may be stale: refresh it first
                        hi_valid_next = 1'b0;
                        if (hi_valid_reg) begin
                            rra_next   = RRA_MTIMEH;
                            state_next = ST_ISSUE;
                        end else begin
                            rra_next   = RRA_MTIME;
                            state_next = ST_PRE_ISSUE;
                        end
                    end else begin
                        if (dec_sel[OFF_MTIME]) begin
                            rra_next      = RRA_MTIME;
                            hi_valid_next = 1'b1;
                        end else if (dec_sel[OFF_MTIMECMP]) begin
                            rra_next = RRA_CMP_LO;
                        end else begin
                            rra_next = RRA_CMP_HI;
                        end
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                rdata_next = reg_read_data;
                ack_next   = 1'b1;
                state_next = ST_RESP;
            end
            ST_PRE_ISSUE: begin
                state_next = ST_PRE_WAIT;
            end
            ST_PRE_WAIT: begin
                rra_next   = RRA_MTIMEH;
                state_next = ST_ISSUE;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_reg    <= ST_IDLE;
            hi_valid_reg <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rdata_reg    <= '0;
            load_lo_reg  <= 1'b0;
            load_hi_reg  <= 1'b0;
            wdata_reg    <= '0;
            rra_reg      <= RRA_PARK;
            irq_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hi_valid_reg <= hi_valid_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            rdata_reg    <= rdata_next;
            load_lo_reg  <= load_lo_next;
            load_hi_reg  <= load_hi_next;
            wdata_reg    <= wdata_next;
            rra_reg      <= rra_next;
            // The timer flag is stale for one cycle after a compare load
            irq_reg      <= timer_triggered && mtie && !(load_lo_reg || load_hi_reg);
        end
    end

    assign mem_ack             = ack_reg;
    assign mem_err             = err_reg;
    assign mem_rdata           = rdata_reg;
    assign irq_mtip            = irq_reg;
    assign load_mtimecmp_low   = load_lo_reg;
    assign load_mtimecmp_high  = load_hi_reg;
    assign mtimecmp_write_data = wdata_reg;
    assign reg_read_addr       = rra_reg;

endmodule

// File: tb/tb_rv2t_mtimer_bus_bridge.sv
// Directed bench for rv2t_mtimer_bus_bridge with a small behavioural timer register port.
module tb_rv2t_mtimer_bus_bridge;

    localparam logic [31:0] BASE    = 32'h2000_0000;
    localparam int          TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic        mtie;
    logic        irq_mtip;
    logic        load_mtimecmp_low;
    logic        load_mtimecmp_high;
    logic [31:0] mtimecmp_write_data;
    logic [1:0]  reg_read_addr;
    logic [31:0] reg_read_data;
    logic        timer_triggered;

    rv2t_mtimer_bus_bridge dut (
        .clk                 (clk),
        .sync_reset          (sync_reset),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_be              (mem_be),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_err             (mem_err),
        .mem_rdata           (mem_rdata),
        .mtie                (mtie),
        .irq_mtip            (irq_mtip),
        .load_mtimecmp_low   (load_mtimecmp_low),
        .load_mtimecmp_high  (load_mtimecmp_high),
        .mtimecmp_write_data (mtimecmp_write_data),
        .reg_read_addr       (reg_read_addr),
        .reg_read_data       (reg_read_data),
        .timer_triggered     (timer_triggered)
    );

    always #5 clk = ~clk;

    // Behavioural timer register port: registered read, high word latched on an mtime read
    logic [63:0] mtime_val = 64'h0;
    logic [63:0] cmp_val   = 64'h0;
    logic [31:0] hi_latch  = 32'h0;
    initial reg_read_data = 32'h0;

    always @(posedge clk) begin
        case (reg_read_addr)
            2'b00: begin
                reg_read_data <= mtime_val[31:0];
                hi_latch      <= mtime_val[63:32];
            end
            2'b01:   reg_read_data <= hi_latch;
            2'b10:   reg_read_data <= cmp_val[31:0];
            default: reg_read_data <= cmp_val[63:32];
        endcase
        if (load_mtimecmp_low)  cmp_val[31:0]  <= mtimecmp_write_data;
        if (load_mtimecmp_high) cmp_val[63:32] <= mtimecmp_write_data;
    end

    // Running counters sampled mid-cycle
    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          ack_cnt = 0;
    int          rra_n = 0;
    logic [31:0] rra_hist = 32'h0;

    always @(negedge clk) begin
        if (load_mtimecmp_low)  lo_cnt++;
        if (load_mtimecmp_high) hi_cnt++;
        if (mem_ack)            ack_cnt++;
        if (reg_read_addr != 2'b10) begin
            rra_n++;
            rra_hist = {rra_hist[29:0], reg_read_addr};
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int chg_at, input logic [63:0] chg_val,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic lo_a, output logic hi_a, output logic [31:0] wd_a);
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_be    = be;
        mem_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == chg_at) mtime_val = chg_val;
        end while (!mem_ack && lat < TIMEOUT);
        if (!mem_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no mem_ack after %0d cycles, required within %0d", lat, TIMEOUT);
        end
        rd   = mem_rdata;
        er   = mem_err;
        lo_a = load_mtimecmp_low;
        hi_a = load_mtimecmp_high;
        wd_a = mtimecmp_write_data;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        pre_en;
        logic [63:0] pre_mtime;
        logic        exp_err;
        int          exp_lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lo;
        int          exp_hi;
        int          exp_n;
        logic [3:0]  exp_codes;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    logic [31:0] rd, wd_a;
    logic        er, lo_a, hi_a;
    int          lat;
    int          lo0, hi0, ack0, n0;
    logic [31:0] mask;

    initial begin
        //          we    addr          be    wd            pre   pre_mtime            err   lat chk   exp_rd        lo hi n codes
        vecs[0]  = '{1'b1, BASE+32'h8,  4'hF, 32'h0000_1234, 1'b0, 64'h0,               1'b0, 1, 1'b0, 32'h0,        1, 0, 0, 4'h0};
        vecs[1]  = '{1'b1, BASE+32'hC,  4'hF, 32'h0000_ABCD, 1'b0, 64'h0,               1'b0, 1, 1'b0, 32'h0,        0, 1, 0, 4'h0};
        vecs[2]  = '{1'b0, BASE+32'h8,  4'hF, 32'h0,         1'b0, 64'h0,               1'b0, 3, 1'b1, 32'h0000_1234, 0, 0, 0, 4'h0};
        vecs[3]  = '{1'b0, BASE+32'hC,  4'hF, 32'h0,         1'b0, 64'h0,               1'b0, 3, 1'b1, 32'h0000_ABCD, 0, 0, 1, 4'h3};
        vecs[4]  = '{1'b0, BASE+32'h0,  4'hF, 32'h0,         1'b1, 64'h5_FFFF_FFF0,     1'b0, 3, 1'b1, 32'hFFFF_FFF0, 0, 0, 1, 4'h0};
        vecs[5]  = '{1'b0, BASE+32'h4,  4'hF, 32'h0,         1'b1, 64'h6_0000_0000,     1'b0, 3, 1'b1, 32'h0000_0005, 0, 0, 1, 4'h1};
        vecs[6]  = '{1'b0, BASE+32'h4,  4'hF, 32'h0,         1'b0, 64'h0,               1'b0, 5, 1'b1, 32'h0000_0006, 0, 0, 2, 4'h1};
        vecs[7]  = '{1'b1, BASE+32'h8,  4'h3, 32'h0000_9999, 1'b0, 64'h0,               1'b1, 1, 1'b0, 32'h0,        0, 0, 0, 4'h0};
        vecs[8]  = '{1'b0, BASE+32'h2,  4'hF, 32'h0,         1'b0, 64'h0,               1'b1, 1, 1'b1, 32'h0,        0, 0, 0, 4'h0};
        vecs[9]  = '{1'b1, BASE+32'h0,  4'hF, 32'h0000_1111, 1'b0, 64'h0,               1'b1, 1, 1'b0, 32'h0,        0, 0, 0, 4'h0};
        vecs[10] = '{1'b1, BASE+32'h4,  4'hF, 32'h0000_2222, 1'b0, 64'h0,               1'b1, 1, 1'b0, 32'h0,        0, 0, 0, 4'h0};
        vecs[11] = '{1'b0, BASE+32'h10, 4'hF, 32'h0,         1'b0, 64'h0,               1'b1, 1, 1'b1, 32'h0,        0, 0, 0, 4'h0};
        vecs[12] = '{1'b0, BASE+32'h8,  4'h1, 32'h0,         1'b0, 64'h0,               1'b0, 3, 1'b1, 32'h0000_1234, 0, 0, 0, 4'h0};
        vecs[13] = '{1'b0, BASE+32'h0,  4'hF, 32'h0,         1'b0, 64'h0,               1'b0, 3, 1'b1, 32'h0000_0000, 0, 0, 1, 4'h0};
        vecs[14] = '{1'b1, BASE+32'h8,  4'hF, 32'h0000_0055, 1'b0, 64'h0,               1'b0, 1, 1'b0, 32'h0,        1, 0, 0, 4'h0};
        vecs[15] = '{1'b0, BASE+32'h4,  4'hF, 32'h0,         1'b0, 64'h0,               1'b0, 5, 1'b1, 32'h0000_0006, 0, 0, 2, 4'h1};
        vecs[16] = '{1'b0, BASE+32'h8,  4'hF, 32'h0,         1'b0, 64'h0,               1'b0, 3, 1'b1, 32'h0000_0055, 0, 0, 0, 4'h0};

        sync_reset = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_be = 4'h0; mem_wdata = 32'h0;
        mtie = 1'b0; timer_triggered = 1'b0;
        repeat (3) @(negedge clk);
        sync_reset = 1'b0;
        @(negedge clk);

        chk("reset_ack", mem_ack, 0);
        chk("reset_err", mem_err, 0);
        chk("reset_rdata", mem_rdata, 0);
        chk("reset_irq", irq_mtip, 0);
        chk("reset_load_lo", load_mtimecmp_low, 0);
        chk("reset_load_hi", load_mtimecmp_high, 0);
        chk("reset_wdata", mtimecmp_write_data, 0);
        chk("reset_rra", reg_read_addr, 2'b10);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].pre_en) mtime_val = vecs[i].pre_mtime;
            lo0 = lo_cnt; hi0 = hi_cnt; ack0 = ack_cnt; n0 = rra_n;
            access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, 0, 64'h0,
                   rd, er, lat, lo_a, hi_a, wd_a);
            $display("txn %0d: we=%0b addr=0x%08h be=0x%0h -> lat=%0d err=%0b rdata=0x%08h",
                     i, vecs[i].we, vecs[i].addr, vecs[i].be, lat, er, rd);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_ack_count", i), 64'(ack_cnt - ack0), 64'd1);
            chk($sformatf("v%0d_lo_pulses", i), 64'(lo_cnt - lo0), 64'(vecs[i].exp_lo));
            chk($sformatf("v%0d_hi_pulses", i), 64'(hi_cnt - hi0), 64'(vecs[i].exp_hi));
            chk($sformatf("v%0d_lo_at_ack", i), lo_a, vecs[i].exp_lo != 0);
            chk($sformatf("v%0d_hi_at_ack", i), hi_a, vecs[i].exp_hi != 0);
            if (vecs[i].exp_lo != 0 || vecs[i].exp_hi != 0)
                chk($sformatf("v%0d_wdata", i), wd_a, vecs[i].wd);
            chk($sformatf("v%0d_rra_issues", i), 64'(rra_n - n0), 64'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0) begin
                mask = (vecs[i].exp_n == 1) ? 32'h3 : 32'hF;
                chk($sformatf("v%0d_rra_seq", i), rra_hist & mask, 32'(vecs[i].exp_codes));
            end
        end

        // Interrupt qualification around a compare write
        @(negedge clk);
        mtie = 1'b1; timer_triggered = 1'b1;
        @(posedge clk); #1;
        chk("irq_set", irq_mtip, 1);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = BASE + 32'h8; mem_be = 4'hF; mem_wdata = 32'h77;
        @(posedge clk); #1;
        chk("irq_wr_ack", mem_ack, 1);
        chk("irq_wr_pulse", load_mtimecmp_low, 1);
        chk("irq_during_pulse", irq_mtip, 1);
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_be = 4'h0; mem_wdata = 32'h0;
        @(posedge clk); #1;
        chk("irq_masked_after_pulse", irq_mtip, 0);
        timer_triggered = 1'b0;
        @(posedge clk); #1;
        chk("irq_cleared", irq_mtip, 0);
        timer_triggered = 1'b1;
        @(posedge clk); #1;
        chk("irq_reassert", irq_mtip, 1);
        mtie = 1'b0;
        @(posedge clk); #1;
        chk("irq_mtie_off", irq_mtip, 0);
        timer_triggered = 1'b0;
        $display("txn irq: sequence done");

        // Reset while the bridge waits on the timer's read data
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = BASE + 32'h8; mem_be = 4'hF;
        @(posedge clk);
        @(posedge clk); #1;
        sync_reset = 1'b1;
        ack0 = ack_cnt;
        @(posedge clk); #1;
        chk("rst_mid_ack", mem_ack, 0);
        chk("rst_mid_rdata", mem_rdata, 0);
        chk("rst_mid_err", mem_err, 0);
        chk("rst_mid_rra", reg_read_addr, 2'b10);
        sync_reset = 1'b0;
        mem_req = 1'b0; mem_addr = 32'h0; mem_be = 4'h0;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_ack", 64'(ack_cnt - ack0), 64'd0);
        $display("txn reset_mid_read: aborted");

        // Cold mtimeh read after reset; mtime moves after the 00 sample
        n0 = rra_n;
        access(1'b0, BASE + 32'h4, 4'hF, 32'h0, 2, 64'h9_0000_0000, rd, er, lat, lo_a, hi_a, wd_a);
        $display("txn cold_mtimeh: lat=%0d err=%0b rdata=0x%08h", lat, er, rd);
        chk("cold_latency", 64'(lat), 64'd5);
        chk("cold_rdata", rd, 32'h0000_0006);
        chk("cold_err", er, 0);
        chk("cold_rra_issues", 64'(rra_n - n0), 64'd2);
        chk("cold_rra_seq", rra_hist & 32'hF, 32'h1);

        access(1'b0, BASE + 32'h8, 4'hF, 32'h0, 0, 64'h0, rd, er, lat, lo_a, hi_a, wd_a);
        $display("txn post_reset_read: lat=%0d err=%0b rdata=0x%08h", lat, er, rd);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_rdata", rd, 32'h0000_0077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
